// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB controller with an 8-entry register file,
// flag-setting ALU and a single req/ack memory port that tolerates wait states.
module multicycle_datapath #(
  parameter int                WIDTH    = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              illegal
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7, OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD = 4'h9, OP_ST = 4'hA, OP_BEQ = 4'hB, OP_JMP = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD, OP_ILL0 = 4'hE, OP_ILL1 = 4'hF;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED} state_t;

  state_t              state_reg;
  logic [15:0]         ir_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [WIDTH-1:0]    a_reg, b_reg, d_reg, result_reg;
  logic [3:0]          flags_reg;
  logic                halted_reg, illegal_reg;
  logic                mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WIDTH-1:0]    mem_wdata_reg;

  logic [3:0]          op;
  logic [2:0]          rd_idx, rs_idx, rt_idx;
  logic [WIDTH-1:0]    imm_ext;
  logic [SH_W-1:0]     sh_amt;
  logic [WIDTH:0]      sum_ext, sh_ext;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c, alu_v, flags_we;
  logic [ADDR_W-1:0]   pc_target;
  logic [3:0]          flags_next;
  logic [WIDTH-1:0]    rf [8];

  assign op      = ir_reg[15:12];
  assign rd_idx  = ir_reg[11:9];
  assign rs_idx  = ir_reg[8:6];
  assign rt_idx  = ir_reg[5:3];
  assign imm_ext = {{(WIDTH-6){ir_reg[5]}}, ir_reg[5:0]};
  assign sh_amt  = b_reg[SH_W-1:0];

  // Register file: one flop bank per entry, written only in WB.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_rf
    logic [WIDTH-1:0] r_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_reg <= '0;
      end else if (state_reg == S_WB && rd_idx == 3'(gi)) begin
        r_reg <= result_reg;
      end
    end
    assign rf[gi] = r_reg;
  end

  // Shifts go through a WIDTH+1 bit window so the last bit shifted out lands in the extra bit.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    flags_we  = 1'b0;
    pc_target = pc_reg;
    sum_ext   = '0;
    sh_ext    = '0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sum_ext  = {1'b0, a_reg} + {1'b0, (op == OP_ADD) ? b_reg : imm_ext};
        alu_res  = sum_ext[WIDTH-1:0];
        alu_c    = sum_ext[WIDTH];
        alu_v    = (a_reg[MSB] == ((op == OP_ADD) ? b_reg[MSB] : imm_ext[MSB])) &&
                   (alu_res[MSB] != a_reg[MSB]);
        flags_we = 1'b1;
      end
      OP_SUB: begin
        sum_ext  = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
        alu_res  = sum_ext[WIDTH-1:0];
        alu_c    = sum_ext[WIDTH];
        alu_v    = (a_reg[MSB] != b_reg[MSB]) && (alu_res[MSB] != a_reg[MSB]);
        flags_we = 1'b1;
      end
      OP_AND: begin alu_res = a_reg & b_reg; flags_we = 1'b1; end
      OP_OR:  begin alu_res = a_reg | b_reg; flags_we = 1'b1; end
      OP_XOR: begin alu_res = a_reg ^ b_reg; flags_we = 1'b1; end
      OP_SHL: begin
        sh_ext   = {1'b0, a_reg} << sh_amt;
        alu_res  = sh_ext[WIDTH-1:0];
        alu_c    = sh_ext[WIDTH];
        flags_we = 1'b1;
      end
      OP_SHR: begin
        sh_ext   = {a_reg, 1'b0} >> sh_amt;
        alu_res  = sh_ext[WIDTH:1];
        alu_c    = sh_ext[0];
        flags_we = 1'b1;
      end
      OP_LD, OP_ST: alu_res = a_reg + imm_ext;
      OP_BEQ: if (d_reg == a_reg) pc_target = pc_reg + imm_ext[ADDR_W-1:0];
      OP_JMP: pc_target = a_reg[ADDR_W-1:0];
      default: ;
    endcase
  end

  assign flags_next = {alu_res[MSB], alu_res == '0, alu_c, alu_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_FETCH;
      ir_reg        <= '0;
      pc_reg        <= RESET_PC;
      a_reg         <= '0;
      b_reg         <= '0;
      d_reg         <= '0;
      result_reg    <= '0;
      flags_reg     <= '0;
      halted_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // Only the very first fetch after reset arrives here without a pending request.
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= pc_reg;
          end else if (mem_ack) begin
            ir_reg      <= mem_rdata[15:0];
            mem_req_reg <= 1'b0;
            state_reg   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg     <= rf[rs_idx];
          b_reg     <= rf[rt_idx];
          d_reg     <= rf[rd_idx];
          pc_reg    <= pc_reg + ADDR_W'(1);
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          result_reg <= alu_res;
          if (flags_we) flags_reg <= flags_next;
          case (op)
            OP_LD, OP_ST: begin
              mem_req_reg  <= 1'b1;
              mem_we_reg   <= (op == OP_ST);
              mem_addr_reg <= alu_res[ADDR_W-1:0];
              if (op == OP_ST) mem_wdata_reg <= d_reg;
              state_reg    <= S_MEM;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI:
              state_reg <= S_WB;
            OP_HALT: begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALTED;
            end
            default: begin
              if (op == OP_ILL0 || op == OP_ILL1) illegal_reg <= 1'b1;
              pc_reg       <= pc_target;
              mem_req_reg  <= 1'b1;
              mem_we_reg   <= 1'b0;
              mem_addr_reg <= pc_target;
              state_reg    <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_req_reg && mem_ack) begin
            mem_we_reg <= 1'b0;
            if (mem_we_reg) begin
              mem_addr_reg <= pc_reg;
              state_reg    <= S_FETCH;
            end else begin
              mem_req_reg <= 1'b0;
              result_reg  <= mem_rdata;
              state_reg   <= S_WB;
            end
          end
        end
        S_WB: begin
          mem_req_reg  <= 1'b1;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= pc_reg;
          state_reg    <= S_FETCH;
        end
        S_HALTED: ;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign pc        = pc_reg;
  assign flags     = flags_reg;
  assign halted    = halted_reg;
  assign illegal   = illegal_reg;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a 16/16 instance with a wait-state memory model and a
// 32-bit / 12-bit-address instance for the reset-during-transfer run.
module tb_multicycle_datapath;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b0, req_a, we_a, ack_a, halted_a, illegal_a;
  logic [15:0] addr_a, wdata_a, rdata_a, pc_a;
  logic [3:0]  flags_a;

  logic        reset_b = 1'b0, req_b, we_b, ack_b, halted_b, illegal_b;
  logic [11:0] addr_b, pc_b;
  logic [31:0] wdata_b, rdata_b;
  logic [3:0]  flags_b;

  multicycle_datapath #(.WIDTH(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .reset(reset_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ack(ack_a), .pc(pc_a), .flags(flags_a),
    .halted(halted_a), .illegal(illegal_a));

  multicycle_datapath #(.WIDTH(32), .ADDR_W(12), .RESET_PC(12'h010)) dut_b (
    .clk(clk), .reset(reset_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ack(ack_b), .pc(pc_b), .flags(flags_b),
    .halted(halted_b), .illegal(illegal_b));

  // Memory model A: ack after wait_a request cycles, fetch log, hold-stability monitor.
  logic [15:0] mem_a [65536];
  int          wait_a = 0, cnt_a = 0, hold_viol = 0, we_cycles = 0;
  logic        ld_en_a = 1'b0, hold_pend = 1'b0, h_we = 1'b0;
  logic [15:0] ld_addr_a = '0, ld_data_a = '0, h_addr = '0, h_wdata = '0;
  logic [15:0] fetch_log [$];

  assign ack_a   = req_a && (cnt_a >= wait_a);
  assign rdata_a = mem_a[addr_a];

  always @(posedge clk) begin
    if (ld_en_a) mem_a[ld_addr_a] <= ld_data_a;
    else if (req_a && ack_a && we_a) mem_a[addr_a] <= wdata_a;
    if (req_a && ack_a && !we_a) fetch_log.push_back(addr_a);
    if (req_a && !ack_a) cnt_a <= cnt_a + 1;
    else cnt_a <= 0;
    if (hold_pend && reset_a && (!req_a || addr_a != h_addr || we_a != h_we || wdata_a != h_wdata))
      hold_viol <= hold_viol + 1;
    if (req_a && we_a) we_cycles <= we_cycles + 1;
    hold_pend <= reset_a && req_a && !ack_a;
    h_addr    <= addr_a;
    h_we      <= we_a;
    h_wdata   <= wdata_a;
  end

  logic [31:0] mem_b [4096];
  int          wait_b = 4, cnt_b = 0;
  logic        ld_en_b = 1'b0;
  logic [11:0] ld_addr_b = '0;
  logic [31:0] ld_data_b = '0;

  assign ack_b   = req_b && (cnt_b >= wait_b);
  assign rdata_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (ld_en_b) mem_b[ld_addr_b] <= ld_data_b;
    else if (req_b && ack_b && we_b) mem_b[addr_b] <= wdata_b;
    if (req_b && !ack_b) cnt_b <= cnt_b + 1;
    else cnt_b <= 0;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [5:0] lo6);
    return {op, rd, rs, lo6};
  endfunction

  task automatic poke_a(input logic [15:0] a, input logic [15:0] d);
    ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
    @(posedge clk); #1;
    ld_en_a = 1'b0;
  endtask

  task automatic poke_b(input logic [11:0] a, input logic [31:0] d);
    ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d;
    @(posedge clk); #1;
    ld_en_b = 1'b0;
  endtask

  task automatic enter_reset_a();
    @(negedge clk); reset_a = 1'b0;
  endtask

  task automatic leave_reset_a();
    @(negedge clk); reset_a = 1'b1;
  endtask

  task automatic wait_halt_a(input string name, input int max_cyc);
    int cyc = 0;
    while (!halted_a && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 64'(halted_a), 64'd1);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Finds the first fetch of 'from' at or after log index 'base' and checks the fetch that follows.
  task automatic check_next(input string name, input int base, input logic [15:0] from,
                            input logic [15:0] exp);
    int idx = -1;
    for (int i = base; i + 1 < fetch_log.size(); i++)
      if (idx < 0 && fetch_log[i] == from) idx = i;
    check(name, (idx >= 0) ? 64'(fetch_log[idx+1]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  lo6;
    logic [15:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam logic [5:0] RT2 = 6'b010_000;
  vec_t vecs [13];

  initial begin
    int base, cyc, hv0, wc0;

    vecs[0]  = '{4'h1, 16'h7FFF, 16'h0001, RT2,       16'h8000, 4'b1001};
    vecs[1]  = '{4'h2, 16'h7FFF, 16'h7FFF, RT2,       16'h0000, 4'b0110};
    vecs[2]  = '{4'h2, 16'h0001, 16'h0002, RT2,       16'hFFFF, 4'b1000};
    vecs[3]  = '{4'h1, 16'hFFFF, 16'h0001, RT2,       16'h0000, 4'b0110};
    vecs[4]  = '{4'h3, 16'hF0F0, 16'h3C3C, RT2,       16'h3030, 4'b0000};
    vecs[5]  = '{4'h4, 16'h8000, 16'h0001, RT2,       16'h8001, 4'b1000};
    vecs[6]  = '{4'h5, 16'hAAAA, 16'hAAAA, RT2,       16'h0000, 4'b0100};
    vecs[7]  = '{4'h6, 16'h8001, 16'h0001, RT2,       16'h0002, 4'b0010};
    vecs[8]  = '{4'h7, 16'h0003, 16'h0001, RT2,       16'h0001, 4'b0010};
    vecs[9]  = '{4'h6, 16'h1234, 16'h0010, RT2,       16'h1234, 4'b0000};
    vecs[10] = '{4'h7, 16'h8000, 16'h000F, RT2,       16'h0001, 4'b0000};
    vecs[11] = '{4'h8, 16'h0005, 16'h0000, 6'b111101, 16'h0002, 4'b0010};
    vecs[12] = '{4'h2, 16'h8000, 16'h0001, RT2,       16'h7FFF, 4'b0011};

    // Reset values, program ADDI/ADDI/ADD/HALT loaded while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(req_a), 64'd0);
    check("rst_mem_we", 64'(we_a), 64'd0);
    check("rst_mem_addr", 64'(addr_a), 64'd0);
    check("rst_mem_wdata", 64'(wdata_a), 64'd0);
    check("rst_pc", 64'(pc_a), 64'd0);
    check("rst_flags", 64'(flags_a), 64'd0);
    check("rst_halted", 64'(halted_a), 64'd0);
    check("rst_illegal", 64'(illegal_a), 64'd0);
    check("rst_pc_b", 64'(pc_b), 64'h010);
    poke_a(16'd0, enc(4'h8, 3'd1, 3'd0, 6'd5));
    poke_a(16'd1, enc(4'h8, 3'd2, 3'd0, 6'b111101));
    poke_a(16'd2, enc(4'h1, 3'd3, 3'd1, RT2));
    poke_a(16'd3, 16'hD000);
    poke_a(16'd4, 16'h0000);
    leave_reset_a();
    #1;
    check("req_low_at_release", 64'(req_a), 64'd0);
    @(posedge clk); #1;
    check("first_req_addr", {47'd0, req_a, addr_a}, {47'd0, 1'b1, 16'h0000});
    wait_halt_a("prog1_halted", 200);
    check("prog1_flags", 64'(flags_a), 64'b0010);
    check("prog1_pc", 64'(pc_a), 64'd4);
    run_cycles(5);
    check("halted_no_req", {62'd0, req_a, halted_a}, {62'd0, 1'b0, 1'b1});
    $display("tx prog1: flags=%b pc=%0h halted=%0d", flags_a, pc_a, halted_a);

    // ALU table: LD r1,[16]; LD r2,[17]; OP r3,r1,(r2|imm); ST r3,[18]; HALT.
    for (int v = 0; v < 13; v++) begin
      enter_reset_a();
      poke_a(16'd0, enc(4'h9, 3'd1, 3'd0, 6'd16));
      poke_a(16'd1, enc(4'h9, 3'd2, 3'd0, 6'd17));
      poke_a(16'd2, enc(vecs[v].op, 3'd3, 3'd1, vecs[v].lo6));
      poke_a(16'd3, enc(4'hA, 3'd3, 3'd0, 6'd18));
      poke_a(16'd4, 16'hD000);
      poke_a(16'd16, vecs[v].a);
      poke_a(16'd17, vecs[v].b);
      poke_a(16'd18, 16'hDEAD);
      leave_reset_a();
      wait_halt_a($sformatf("vec%0d_halted", v), 200);
      check($sformatf("vec%0d_result", v), 64'(mem_a[18]), 64'(vecs[v].exp_res));
      check($sformatf("vec%0d_flags", v), 64'(flags_a), 64'(vecs[v].exp_flags));
      $display("tx vec%0d: op=%h a=%h b=%h res=%h flags=%b", v, vecs[v].op, vecs[v].a,
               vecs[v].b, mem_a[18], flags_a);
    end

    // ST then LD through address 0x20 with three wait states on every transfer.
    enter_reset_a();
    poke_a(16'd0, enc(4'h9, 3'd1, 3'd0, 6'd16));
    poke_a(16'd1, enc(4'h8, 3'd5, 3'd0, 6'd16));
    poke_a(16'd2, enc(4'hA, 3'd1, 3'd5, 6'd16));
    poke_a(16'd3, enc(4'h9, 3'd4, 3'd5, 6'd16));
    poke_a(16'd4, enc(4'hA, 3'd4, 3'd5, 6'd17));
    poke_a(16'd5, 16'hD000);
    poke_a(16'd16, 16'h5A5A);
    poke_a(16'h20, 16'h0000);
    poke_a(16'h21, 16'h0000);
    wait_a = 3;
    hv0 = hold_viol;
    wc0 = we_cycles;
    leave_reset_a();
    wait_halt_a("stld_halted", 400);
    check("st_mem_0x20", 64'(mem_a[16'h20]), 64'h5A5A);
    check("ld_r4_store", 64'(mem_a[16'h21]), 64'h5A5A);
    check("hold_stable", 64'(hold_viol - hv0), 64'd0);
    check("st_req_cycles", 64'(we_cycles - wc0), 64'd8);
    $display("tx stld: m20=%h m21=%h write_cycles=%0d", mem_a[16'h20], mem_a[16'h21], we_cycles - wc0);
    wait_a = 0;

    // BEQ taken at 5 with imm -6 loops back to 0.
    enter_reset_a();
    for (int i = 0; i < 5; i++) poke_a(16'(i), 16'h0000);
    poke_a(16'd5, enc(4'hB, 3'd0, 3'd0, 6'b111010));
    base = fetch_log.size();
    leave_reset_a();
    run_cycles(40);
    check_next("beq_taken", base, 16'd5, 16'd0);
    $display("tx beq_taken: fetches=%0d", fetch_log.size() - base);

    // BEQ not taken falls through to 6; JMP r2=0xFFFF then wraps to 0.
    enter_reset_a();
    poke_a(16'd0, enc(4'h8, 3'd1, 3'd0, 6'd1));
    poke_a(16'd1, enc(4'h8, 3'd2, 3'd0, 6'h3F));
    for (int i = 2; i < 5; i++) poke_a(16'(i), 16'h0000);
    poke_a(16'd5, enc(4'hB, 3'd1, 3'd0, 6'b111010));
    poke_a(16'd6, enc(4'hC, 3'd0, 3'd2, 6'd0));
    poke_a(16'hFFFF, 16'h0000);
    base = fetch_log.size();
    leave_reset_a();
    run_cycles(60);
    check_next("beq_not_taken", base, 16'd5, 16'd6);
    check_next("jmp_target", base, 16'd6, 16'hFFFF);
    check_next("pc_wrap", base, 16'hFFFF, 16'h0000);
    $display("tx beq_nt_jmp: fetches=%0d", fetch_log.size() - base);

    // Illegal opcode is sticky and leaves registers and flags alone.
    enter_reset_a();
    poke_a(16'd0, enc(4'h8, 3'd1, 3'd0, 6'h3F));
    poke_a(16'd1, 16'hF3FF);
    poke_a(16'd2, 16'h0000);
    poke_a(16'd3, enc(4'hA, 3'd1, 3'd0, 6'd16));
    poke_a(16'd4, 16'hD000);
    poke_a(16'd16, 16'h0000);
    leave_reset_a();
    wait_halt_a("ill_halted", 200);
    check("ill_sticky", 64'(illegal_a), 64'd1);
    check("ill_flags", 64'(flags_a), 64'b1000);
    check("ill_r1", 64'(mem_a[16]), 64'hFFFF);
    $display("tx illegal: illegal=%0d flags=%b r1=%h", illegal_a, flags_a, mem_a[16]);

    // Reset while a load waits in MEM (16-bit instance).
    enter_reset_a();
    poke_a(16'd0, enc(4'h9, 3'd1, 3'd0, 6'd16));
    wait_a = 6;
    leave_reset_a();
    cyc = 0;
    while (!(req_a && !we_a && addr_a == 16'd16) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("a_ld_req_seen", {47'd0, req_a, addr_a}, {47'd0, 1'b1, 16'd16});
    @(posedge clk);
    @(negedge clk); reset_a = 1'b0;
    #1;
    check("a_midrst_req", 64'(req_a), 64'd0);
    check("a_midrst_addr", 64'(addr_a), 64'd0);
    check("a_midrst_pc", 64'(pc_a), 64'd0);
    leave_reset_a();
    @(posedge clk); #1;
    check("a_refetch", {47'd0, req_a, addr_a}, {47'd0, 1'b1, 16'h0000});
    $display("tx a_midrst: req=%0d addr=%h", req_a, addr_a);

    // 32-bit instance: ADDI/ADD/ST then reset while LD waits; refetch from 0x010.
    poke_b(12'h010, {16'h0, enc(4'h8, 3'd1, 3'd0, 6'h3F)});
    poke_b(12'h011, {16'h0, enc(4'h1, 3'd2, 3'd1, 6'b001_000)});
    poke_b(12'h012, {16'h0, enc(4'hA, 3'd2, 3'd0, 6'd8)});
    poke_b(12'h013, {16'h0, enc(4'h9, 3'd3, 3'd0, 6'd9)});
    poke_b(12'h008, 32'h0);
    @(negedge clk); reset_b = 1'b1;
    cyc = 0;
    while (!(req_b && !we_b && addr_b == 12'd9) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b_ld_req_seen", {51'd0, req_b, addr_b}, {51'd0, 1'b1, 12'd9});
    check("b_flags", 64'(flags_b), 64'b1010);
    check("b_st_data", 64'(mem_b[8]), 64'hFFFF_FFFE);
    @(posedge clk);
    @(negedge clk); reset_b = 1'b0;
    #1;
    check("b_midrst_req", 64'(req_b), 64'd0);
    check("b_midrst_pc", 64'(pc_b), 64'h010);
    check("b_midrst_flags", 64'(flags_b), 64'd0);
    check("b_midrst_wdata", 64'(wdata_b), 64'd0);
    check("b_midrst_addr", 64'(addr_b), 64'd0);
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    check("b_refetch", {51'd0, req_b, addr_b}, {51'd0, 1'b1, 12'h010});
    $display("tx b_midrst: req=%0d addr=%h pc=%h", req_b, addr_b, pc_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
